dll_lock_ctrl: RTL and testbench

Calibration and tracking controller for the 512-tap DLL delay line in the eMMC clocking path. It drives the 9-bit tap select of the master delay line. A 9-step successive-approximation search makes the line's delay equal one reference clock period, as judged by an external phase detector. After lock it tracks voltage and temperature drift with filtered ±1 tap steps, and derives a quarter-period (90°) select for the slave delay line used for sampling.

---
 rtl/dll_lock_ctrl.sv | 153 +++++++++++++++
 tb/tb_dll_lock_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/dll_lock_ctrl.sv
// DLL master delay-line lock controller.
// 9-bit SAR calibration, filtered drift tracking and quarter-period select.
module dll_lock_ctrl #(
  parameter int unsigned SETTLE_CYC = 16,
  parameter int unsigned TRACK_FILT = 4
) (
  input  logic       HCLK,
  input  logic       HRESETn,
  input  logic       start_i,
  input  logic       track_en_i,
  input  logic       pd_early_i,
  output logic [8:0] sel_index_o,
  output logic [6:0] sel_qtr_o,
  output logic       locked_o,
  output logic       busy_o,
  output logic       err_o
);

  localparam int CW = $clog2(SETTLE_CYC);
  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYC - 1);
  localparam logic [3:0] RUN_LAST = 4'(TRACK_FILT);

  typedef enum logic [1:0] {
    IDLE,
    SEARCH,
    LOCKED
  } state_t;

  state_t state, state_nx;

  logic          pd_m, pd_s;
  logic [8:0]    sel, sel_nx;
  logic [8:0]    res, res_nx;
  logic [8:0]    mask;
  logic [3:0]    bit_idx, bit_nx;
  logic [3:0]    run, run_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          dir, dir_nx;
  logic          locked, locked_nx;
  logic          busy, busy_nx;
  logic          err, err_nx;

  assign mask = 9'd1 << bit_idx;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      pd_m    <= 1'b0;
      pd_s    <= 1'b0;
      state   <= IDLE;
      sel     <= '0;
      res     <= '0;
      bit_idx <= '0;
      run     <= '0;
      cnt     <= '0;
      dir     <= 1'b0;
      locked  <= 1'b0;
      busy    <= 1'b0;
      err     <= 1'b0;
    end else begin
      pd_m    <= pd_early_i;
      pd_s    <= pd_m;
      state   <= state_nx;
      sel     <= sel_nx;
      res     <= res_nx;
      bit_idx <= bit_nx;
      run     <= run_nx;
      cnt     <= cnt_nx;
      dir     <= dir_nx;
      locked  <= locked_nx;
      busy    <= busy_nx;
      err     <= err_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    sel_nx    = sel;
    res_nx    = res;
    bit_nx    = bit_idx;
    run_nx    = run;
    cnt_nx    = cnt;
    dir_nx    = dir;
    locked_nx = locked;
    busy_nx   = busy;
    err_nx    = err;

    unique case (state)
      IDLE: ;
      SEARCH: begin
        if (cnt != CNT_LAST) begin
          cnt_nx = cnt + CW'(1);
        end else begin
          cnt_nx = '0;
          res_nx = pd_s ? (res | mask) : res;
          if (bit_idx == 4'd0) begin
            sel_nx    = res_nx;
            state_nx  = LOCKED;
            locked_nx = 1'b1;
            busy_nx   = 1'b0;
            err_nx    = (res_nx == 9'd0) || (res_nx == 9'd511);
          end else begin
            bit_nx = bit_idx - 4'd1;
            sel_nx = res_nx | (mask >> 1);
          end
        end
      end
      LOCKED: begin
        if (!track_en_i) begin
          cnt_nx = '0;
          run_nx = '0;
        end else if (cnt != CNT_LAST) begin
          cnt_nx = cnt + CW'(1);
        end else begin
          cnt_nx = '0;
          dir_nx = pd_s;
          // a reversal restarts the run at this vote
          run_nx = (run != 4'd0 && pd_s == dir) ? run + 4'd1 : 4'd1;
          if (run_nx == RUN_LAST) begin
            run_nx = '0;
            if (pd_s) begin
              if (sel == 9'd511) err_nx = 1'b1;
              else               sel_nx = sel + 9'd1;
            end else begin
              if (sel == 9'd0) err_nx = 1'b1;
              else             sel_nx = sel - 9'd1;
            end
          end
        end
      end
      default: state_nx = IDLE;
    endcase

    if (start_i) begin
      state_nx  = SEARCH;
      sel_nx    = 9'd256;
      res_nx    = '0;
      bit_nx    = 4'd8;
      cnt_nx    = '0;
      run_nx    = '0;
      dir_nx    = 1'b0;
      locked_nx = 1'b0;
      busy_nx   = 1'b1;
      err_nx    = 1'b0;
    end
  end

  assign sel_index_o = sel;
  assign sel_qtr_o   = sel[8:2];
  assign locked_o    = locked;
  assign busy_o      = busy;
  assign err_o       = err;

endmodule

// File: tb/tb_dll_lock_ctrl.sv
// Bench for dll_lock_ctrl: phase-detector model driven from the select,
// scoreboard of expected select changes, timing and saturation checks.
module tb_dll_lock_ctrl;

  logic       HCLK = 1'b0;
  logic       HRESETn;
  logic       start;
  logic       track_en;
  logic       pd_early;
  logic [8:0] sel;
  logic [6:0] qtr;
  logic       locked, busy, err;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int mode = 0;
  int thr = 300;
  int exp_q[$];
  bit mon = 1'b0;
  bit gap_chk = 1'b0;
  int last_chg = 0;
  logic [8:0] prev = '0;

  dll_lock_ctrl dut (
    .HCLK(HCLK),
    .HRESETn(HRESETn),
    .start_i(start),
    .track_en_i(track_en),
    .pd_early_i(pd_early),
    .sel_index_o(sel),
    .sel_qtr_o(qtr),
    .locked_o(locked),
    .busy_o(busy),
    .err_o(err)
  );

  always #5 HCLK = ~HCLK;

  always @(posedge HCLK) cyc <= cyc + 1;

  always_comb begin
    pd_early = 1'b0;
    case (mode)
      0: pd_early = (int'(sel) < thr);
      1: pd_early = 1'b1;
      2: pd_early = 1'b0;
      default: pd_early = cyc[4];
    endcase
  end

  task automatic chk(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  always @(negedge HCLK) begin
    if (mon && sel !== prev) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected", int'(sel), int'(prev));
      end else begin
        chk("sb_sel", int'(sel), exp_q.pop_front());
        if (gap_chk) chk("sb_gap", cyc - last_chg, 64);
      end
      last_chg = cyc;
    end
    prev = sel;
  end

  task automatic pulse_start();
    @(negedge HCLK);
    start = 1'b1;
    @(posedge HCLK);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_lock(output int n);
    n = 0;
    do begin
      @(posedge HCLK);
      n++;
      @(negedge HCLK);
    end while (!locked && n < 1000);
  endtask

  int n;
  logic [8:0] hold;

  initial begin
    HRESETn  = 1'b0;
    start    = 1'b0;
    track_en = 1'b0;
    repeat (3) @(posedge HCLK);
    @(negedge HCLK);
    chk("rst_sel", int'(sel), 0);
    chk("rst_qtr", int'(qtr), 0);
    chk("rst_lock", int'(locked), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_err", int'(err), 0);
    HRESETn = 1'b1;
    repeat (20) @(posedge HCLK);
    @(negedge HCLK);
    chk("idle_sel", int'(sel), 0);
    chk("idle_busy", int'(busy), 0);

    // SAR search against a threshold of 300
    mode = 0;
    thr  = 300;
    exp_q = '{256, 384, 320, 288, 304, 296, 300, 298, 299};
    mon  = 1'b1;
    pulse_start();
    chk("start_sel", int'(sel), 256);
    chk("start_busy", int'(busy), 1);
    wait_lock(n);
    chk("lock_lat", n, 144);
    chk("lock_sel", int'(sel), 299);
    chk("lock_qtr", int'(qtr), 74);
    chk("lock_busy", int'(busy), 0);
    chk("lock_err", int'(err), 0);
    chk("sb_drain1", exp_q.size(), 0);

    // drift tracking toward 303
    track_en = 1'b1;
    thr      = 303;
    gap_chk  = 1'b1;
    last_chg = cyc;
    exp_q    = '{300, 301, 302, 303, 302, 303};
    repeat (420) @(posedge HCLK);
    @(negedge HCLK);
    track_en = 1'b0;
    chk("sb_drain2", exp_q.size(), 0);
    chk("trk_sel", int'(sel), 303);

    thr  = 100;
    hold = sel;
    repeat (200) @(posedge HCLK);
    @(negedge HCLK);
    chk("frozen", int'(sel), int'(hold));

    mode     = 3;
    track_en = 1'b1;
    repeat (400) @(posedge HCLK);
    @(negedge HCLK);
    chk("alt_hold", int'(sel), int'(hold));
    track_en = 1'b0;
    mon      = 1'b0;
    gap_chk  = 1'b0;

    // saturation high, then tracking into the rail
    mode = 1;
    pulse_start();
    wait_lock(n);
    chk("sat_hi_lat", n, 144);
    chk("sat_hi_sel", int'(sel), 511);
    chk("sat_hi_err", int'(err), 1);
    chk("sat_hi_lock", int'(locked), 1);
    track_en = 1'b1;
    repeat (85) @(posedge HCLK);
    @(negedge HCLK);
    chk("rail_sel", int'(sel), 511);
    chk("rail_err", int'(err), 1);
    track_en = 1'b0;

    // saturation low; start must clear the sticky error
    mode = 2;
    pulse_start();
    chk("err_clr", int'(err), 0);
    chk("relock_clr", int'(locked), 0);
    wait_lock(n);
    chk("sat_lo_sel", int'(sel), 0);
    chk("sat_lo_err", int'(err), 1);

    // restart at cycle 70 of a search
    mode = 0;
    thr  = 300;
    pulse_start();
    repeat (69) @(posedge HCLK);
    chk("pre_rst_sel", int'(sel), 304);
    pulse_start();
    chk("rs_sel", int'(sel), 256);
    chk("rs_busy", int'(busy), 1);
    chk("rs_lock", int'(locked), 0);
    wait_lock(n);
    chk("rs_lat", n, 144);
    chk("rs_fin", int'(sel), 299);

    // asynchronous reset mid-search
    pulse_start();
    repeat (40) @(posedge HCLK);
    #3;
    HRESETn = 1'b0;
    #1;
    chk("ar_sel", int'(sel), 0);
    chk("ar_qtr", int'(qtr), 0);
    chk("ar_lock", int'(locked), 0);
    chk("ar_busy", int'(busy), 0);
    chk("ar_err", int'(err), 0);
    @(negedge HCLK);
    HRESETn = 1'b1;
    repeat (50) @(posedge HCLK);
    @(negedge HCLK);
    chk("post_sel", int'(sel), 0);
    chk("post_busy", int'(busy), 0);
    chk("post_lock", int'(locked), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
